// File: rtl/uart_echo_master.sv
// Hardware UART echo: polls CON, drains RXD into a small FIFO and writes the bytes back to TXD.
// Runs as a bus initiator on the shared peripheral bus whenever enable is high.
module uart_echo_master #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     enable,
    output logic                     rd,
    output logic                     wr,
    output logic [31:0]              addr,
    output logic [31:0]              wdata,
    input  logic [31:0]              rdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    typedef enum logic [2:0] {
        IDLE, POLL, READ_RX, CLR_TX, WRITE_TX, GAP
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               tx_free;
    logic [GAP_W-1:0]   gap_cnt;
    logic               fifo_full, fifo_empty, gap_done, push, pop;
    logic               rd_next, wr_next;
    logic [31:0]        addr_next, wdata_next;
    logic               rdata_unused;

    assign fifo_full    = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty   = (fifo_count == '0);
    assign gap_done     = (POLL_GAP <= 1) || (gap_cnt == GAP_W'(POLL_GAP - 1));
    assign push         = (state == READ_RX) && !fifo_full;
    assign pop          = (state == WRITE_TX);
    assign rdata_unused = ^rdata[31:8];

    // Next state, plus bus strobes decoded from the state being entered so they launch from flops
    always_comb begin
        state_next = state;
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
        case (state)
            IDLE:     if (enable) state_next = POLL;
            POLL: begin
                if (!enable)                     state_next = IDLE;
                else if (rdata[3])               state_next = READ_RX;
                else if (rdata[2] && !tx_free)   state_next = CLR_TX;
                else if (tx_free && !fifo_empty) state_next = WRITE_TX;
                else                             state_next = GAP;
            end
            READ_RX, CLR_TX, WRITE_TX: state_next = enable ? GAP : IDLE;
            GAP: begin
                if (!enable)      state_next = IDLE;
                else if (gap_done) state_next = POLL;
            end
            default:  state_next = IDLE;
        endcase
        case (state_next)
            POLL:     begin rd_next = 1'b1; addr_next = ADDR_CON; end
            READ_RX:  begin rd_next = 1'b1; addr_next = ADDR_RXD; end
            CLR_TX:   begin rd_next = 1'b1; addr_next = ADDR_TXD; end
            WRITE_TX: begin
                wr_next    = 1'b1;
                addr_next  = ADDR_TXD;
                wdata_next = {24'b0, mem[rd_ptr]};
            end
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            rd    <= 1'b0;
            wr    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            rd    <= rd_next;
            wr    <= wr_next;
            addr  <= addr_next;
            wdata <= wdata_next;
            busy  <= (state_next != IDLE);
        end
    end

    // FIFO bookkeeping, TX ownership and sticky overflow
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_free    <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                fifo_count <= fifo_count + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                fifo_count <= fifo_count - 1'b1;
                tx_free    <= 1'b0;
            end
            if (state == CLR_TX) tx_free <= 1'b1;
            if ((state == READ_RX) && fifo_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= rdata[7:0];
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)                              gap_cnt <= '0;
        else if (state == GAP && state_next == GAP) gap_cnt <= gap_cnt + 1'b1;
        else                                       gap_cnt <= '0;
    end

endmodule

// File: tb/tb_uart_echo_master.sv
// Directed bench for uart_echo_master with a behavioural UART register responder.
module tb_uart_echo_master;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        enable;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  fifo_count;
    logic        overflow, busy;

    int checks = 0;
    int errors = 0;

    // Responder state
    logic [7:0] rx_mem [64];
    int         rx_head = 0, rx_tail = 0;
    logic       tx_done = 1'b0;
    logic       auto_done = 1'b0;
    int         tx_req = 0, tx_ack = 0;
    logic [7:0] tx_log [32];
    int         tx_n = 0, rxd_reads = 0, txd_reads = 0;

    uart_echo_master #(.DEPTH(8), .POLL_GAP(0)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .enable(enable),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
        .fifo_count(fifo_count), .overflow(overflow), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        rdata = '0;
        if (rd && addr == CON)      rdata = {28'b0, (rx_head != rx_tail), tx_done, 2'b0};
        else if (rd && addr == RXD) rdata = {24'b0, rx_mem[rx_head % 64]};
    end

    always @(posedge CLK) begin
        if (!Reset_n) begin
            rx_head <= rx_tail; tx_done <= 1'b0; tx_ack <= tx_req;
            tx_n <= 0; rxd_reads <= 0; txd_reads <= 0;
        end else begin
            if (rd && addr == RXD) begin
                rxd_reads <= rxd_reads + 1;
                if (rx_head != rx_tail) rx_head <= rx_head + 1;
            end
            if (rd && addr == TXD) begin tx_done <= 1'b0; txd_reads <= txd_reads + 1; end
            if (tx_ack != tx_req) begin tx_done <= 1'b1; tx_ack <= tx_req; end
            if (wr && addr == TXD) begin
                if (tx_n < 32) tx_log[tx_n] <= wdata[7:0];
                tx_n <= tx_n + 1;
                if (auto_done) tx_done <= 1'b1;
            end
        end
    end

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_tail % 64] = b;
        rx_tail = rx_tail + 1;
    endtask

    task automatic apply_reset();
        enable  = 1'b0;
        Reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        enable  = 1'b1;
        Reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %0h exp 0", rd); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0h exp 0", wr); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %0h exp 0", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", overflow); end
        Reset_n = 1'b1;
        for (int k = 0; k < 10 && rd !== 1'b1; k++) @(negedge CLK);
        checks++; if (rd !== 1'b1 || addr !== CON) begin
            errors++; $display("FAIL reset_first_rd got rd=%0h addr=%0h exp rd=1 addr=%0h", rd, addr, CON);
        end
        enable = 1'b0;
        for (int k = 0; k < 10 && busy !== 1'b0; k++) @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0h exp 0", busy); end
    endtask

    task automatic test_single_echo();
        auto_done = 1'b0;
        apply_reset();
        push_rx(8'h5A);
        enable = 1'b1;
        @(negedge CLK);
        checks++; if (rd !== 1'b1 || addr !== CON) begin errors++; $display("FAIL echo_poll got rd=%0h addr=%0h exp 1 %0h", rd, addr, CON); end
        @(negedge CLK);
        checks++; if (rd !== 1'b1 || addr !== RXD) begin errors++; $display("FAIL echo_rxd got rd=%0h addr=%0h exp 1 %0h", rd, addr, RXD); end
        @(negedge CLK);
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL echo_count1 got %0d exp 1", fifo_count); end
        repeat (2) @(negedge CLK);
        checks++; if (wr !== 1'b1 || addr !== TXD || wdata !== 32'h5A) begin
            errors++; $display("FAIL echo_write got wr=%0h addr=%0h wdata=%0h exp 1 %0h 5a", wr, addr, wdata, TXD);
        end
        @(negedge CLK);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL echo_count0 got %0d exp 0", fifo_count); end
        enable = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        auto_done = 1'b0;
        apply_reset();
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
        enable = 1'b1;
        repeat (40) @(negedge CLK);
        checks++; if (tx_n !== 1) begin errors++; $display("FAIL bp_writes got %0d exp 1", tx_n); end
        checks++; if (tx_log[0] !== 8'h11) begin errors++; $display("FAIL bp_byte0 got %0h exp 11", tx_log[0]); end
        checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", fifo_count); end
        checks++; if (txd_reads !== 0) begin errors++; $display("FAIL bp_txd_reads0 got %0d exp 0", txd_reads); end
        tx_req = tx_req + 1;
        for (int k = 0; k < 20 && wr !== 1'b1; k++) @(negedge CLK);
        checks++; if (wr !== 1'b1 || wdata !== 32'h22) begin errors++; $display("FAIL bp_write2 got wr=%0h wdata=%0h exp 1 22", wr, wdata); end
        checks++; if (txd_reads !== 1) begin errors++; $display("FAIL bp_clr_tx got %0d exp 1", txd_reads); end
        repeat (10) @(negedge CLK);
        checks++; if (tx_n !== 2 || fifo_count !== 4'd1) begin
            errors++; $display("FAIL bp_after got writes=%0d count=%0d exp 2 1", tx_n, fifo_count);
        end
        enable = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_overflow();
        auto_done = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) push_rx(8'hA0 + 8'(i));
        enable = 1'b1;
        for (int k = 0; k < 60 && rxd_reads < 10; k++) @(negedge CLK);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
        repeat (20) @(negedge CLK);
        checks++; if (tx_n !== 1) begin errors++; $display("FAIL ovf_one_write got %0d exp 1", tx_n); end
        auto_done = 1'b1;
        tx_req = tx_req + 1;
        repeat (80) @(negedge CLK);
        checks++; if (tx_n !== 8) begin errors++; $display("FAIL ovf_writes got %0d exp 8", tx_n); end
        checks++; if (rxd_reads !== 10) begin errors++; $display("FAIL ovf_rxd_reads got %0d exp 10", rxd_reads); end
        checks++; if (fifo_count !== 4'd0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_final got count=%0d ovf=%0h exp 0 1", fifo_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_log[i] !== 8'hA0 + 8'(i)) begin
                errors++; $display("FAIL ovf_order[%0d] got %0h exp %0h", i, tx_log[i], 8'hA0 + 8'(i));
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_wrap();
        auto_done = 1'b1;
        apply_reset();
        enable = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) push_rx(8'((b * 4 + i) * 7 + 3));
            for (int k = 0; k < 200 && tx_n < 4 * (b + 1); k++) @(negedge CLK);
        end
        checks++; if (tx_n !== 20) begin errors++; $display("FAIL wrap_writes got %0d exp 20", tx_n); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (tx_log[i] !== 8'(i * 7 + 3)) begin
                errors++; $display("FAIL wrap_order[%0d] got %0h exp %0h", i, tx_log[i], 8'(i * 7 + 3));
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_disable();
        auto_done = 1'b1;
        apply_reset();
        push_rx(8'h61); push_rx(8'h62); push_rx(8'h63);
        enable = 1'b1;
        for (int k = 0; k < 20 && !(rd === 1'b1 && addr === RXD); k++) @(negedge CLK);
        checks++; if (rd !== 1'b1 || addr !== RXD) begin errors++; $display("FAIL dis_read_rx got rd=%0h addr=%0h exp 1 %0h", rd, addr, RXD); end
        enable = 1'b0;
        @(negedge CLK);
        checks++; if (busy !== 1'b0 || rd !== 1'b0) begin errors++; $display("FAIL dis_idle got busy=%0h rd=%0h exp 0 0", busy, rd); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL dis_count got %0d exp 1", fifo_count); end
        repeat (5) @(negedge CLK);
        checks++; if (fifo_count !== 4'd1 || rxd_reads !== 1) begin
            errors++; $display("FAIL dis_hold got count=%0d reads=%0d exp 1 1", fifo_count, rxd_reads);
        end
        enable = 1'b1;
        for (int k = 0; k < 200 && tx_n < 3; k++) @(negedge CLK);
        checks++; if (tx_n !== 3) begin errors++; $display("FAIL dis_writes got %0d exp 3", tx_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (tx_log[i] !== 8'h61 + 8'(i)) begin
                errors++; $display("FAIL dis_order[%0d] got %0h exp %0h", i, tx_log[i], 8'h61 + 8'(i));
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        Reset_n = 1'b0;
        enable  = 1'b0;
        test_reset();
        test_single_echo();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
